// File: rtl/nibble_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
// State encoding, nibble width and nibble-count helper.
package nibble_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int NIB_W = 4;

  function automatic int nib_count(input int width);
    return width / NIB_W;
  endfunction

endpackage

// File: rtl/nibble_serial_adder_carry_select.sv
// 4-bit carry-select adder: low pair ripples, high pair
// is computed for both carry values and then selected.
module carry_select (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic [3:0] S,
  output logic       cout
);

  logic [2:0] w_lo;
  logic [2:0] w_hi0;
  logic [2:0] w_hi1;

  assign w_lo  = {1'b0, A[1:0]} + {1'b0, B[1:0]} + {2'b00, cin};
  assign w_hi0 = {1'b0, A[3:2]} + {1'b0, B[3:2]};
  assign w_hi1 = {1'b0, A[3:2]} + {1'b0, B[3:2]} + 3'd1;

  always_comb begin
    S[1:0] = w_lo[1:0];
    S[3:2] = w_hi0[1:0];
    cout   = w_hi0[2];
    if (w_lo[2]) begin
      S[3:2] = w_hi1[1:0];
      cout   = w_hi1[2];
    end
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that reuses one 4-bit carry_select over WIDTH/4
// nibbles, LSB first, with a registered inter-nibble carry.
module nibble_serial_adder
  import nibble_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB   = nib_count(WIDTH);
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t r_state;
  state_t w_next;

  logic [NIB-1:0][NIB_W-1:0] r_a;
  logic [NIB-1:0][NIB_W-1:0] r_b;
  logic [NIB-1:0][NIB_W-1:0] r_sum;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_carry;
  logic                      r_cout;
  logic                      r_ovf;

  logic [NIB_W-1:0] w_s;
  logic             w_co;
  logic             w_last;
  logic             w_ovf;
  logic             w_msb_a;
  logic             w_msb_b;

  carry_select u_cs (
    .A    (r_a[r_idx]),
    .B    (r_b[r_idx]),
    .cin  (r_carry),
    .S    (w_s),
    .cout (w_co)
  );

  assign w_last  = (r_idx == IDX_W'(NIB - 1));
  assign w_msb_a = r_a[NIB-1][NIB_W-1];
  assign w_msb_b = r_b[NIB-1][NIB_W-1];
  // only meaningful on the last step, where w_s is the top nibble
  assign w_ovf   = (w_msb_a == w_msb_b) && (w_s[NIB_W-1] != w_msb_a);

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_sum[r_idx] <= w_s;
          r_carry      <= w_co;
          if (w_last) begin
            r_idx  <= '0;
            r_cout <= w_co;
            r_ovf  <= w_ovf;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
